fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_skid.sv | 28 ++
 rtl/fetch_unit.sv | 82 ++++++++
 tb/tb_fetch_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, constants and the pc/instruction packet type for the fetch front end.
package fetch_pkg;
    localparam int          XLEN             = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register that parks an instruction while decode stalls.
module fetch_skid
    import fetch_pkg::fetch_pkt_t;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       capture,
    input  logic       drain,
    input  logic       flush,
    input  fetch_pkt_t din,
    output logic       v,
    output fetch_pkt_t q
);
    // flush beats capture so a redirect never leaves a stale entry behind
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v <= 1'b0;
            q <= '0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (capture) begin
            v <= 1'b1;
            q <= din;
        end else if (drain) begin
            v <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the rom address, tracks its 1-cycle read
// latency, absorbs decode stalls in a skid entry and handles pc redirects.
module fetch_unit
    import fetch_pkg::fetch_pkt_t, fetch_pkg::INSTR_BYTES, fetch_pkg::RESET_PC_DEFAULT;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    output logic [XLEN-1:0] rom_a,
    input  logic [XLEN-1:0] rom_q,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic [XLEN-1:0] redir_pc;
    logic            inflight_v;
    logic            skid_v;
    logic            issue;
    logic            capture;
    logic            drain;
    fetch_pkt_t      rom_pkt;
    fetch_pkt_t      skid_pkt;

    assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign issue    = redirect_valid | out_ready | (~skid_v & ~inflight_v);
    // rom always reads; an unissued address is simply discarded next cycle
    assign rom_a    = RST            ? RESET_PC :
                      redirect_valid ? redir_pc : fetch_pc;

    assign capture  = inflight_v & ~skid_v & ~out_ready;
    assign drain    = skid_v & out_ready;
    assign rom_pkt  = '{pc: inflight_pc, instr: rom_q};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc    <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight_v <= issue;
            if (issue) begin
                inflight_pc <= rom_a;
                fetch_pc    <= rom_a + XLEN'(INSTR_BYTES);
            end
        end
    end

    fetch_skid u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .capture (capture),
        .drain   (drain),
        .flush   (redirect_valid),
        .din     (rom_pkt),
        .v       (skid_v),
        .q       (skid_pkt)
    );

    always_comb begin
        logic vld;
        vld       = (skid_v | inflight_v) & ~redirect_valid;
        out_valid = vld;
        out_pc    = '0;
        out_instr = '0;
        if (vld) begin
            if (skid_v) begin
                out_pc    = skid_pkt.pc;
                out_instr = skid_pkt.instr;
            end else begin
                out_pc    = inflight_pc;
                out_instr = rom_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a registered rom holding mem[i]=0x1000+i.
module tb_fetch_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] rom_a, rom_q, redirect_pc, out_pc, out_instr;
    logic        redirect_valid = 1'b0, out_valid, out_ready = 1'b1;
    int          passed = 0, total = 0;

    always #5 CLK = ~CLK;

    initial rom_q = '0;
    always @(posedge CLK) rom_q <= 32'h1000 + (rom_a >> 2);

    fetch_unit dut (
        .CLK(CLK), .RST(RST), .rom_a(rom_a), .rom_q(rom_q),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // state is settled 1 time unit after each rising edge
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins);
        #1;
        chk({tag, ".v"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, out_instr, ins);
    endtask

    always @(negedge CLK)
        if (!RST) chk("invariant", {31'b0, dut.skid_v & dut.inflight_v}, 32'h0);

    initial begin
        redirect_pc = '0;
        // reset state
        tick();
        expect_out("rst", 1'b0, 32'h0, 32'h0);
        chk("rst.rom_a", rom_a, 32'h0);
        RST = 1'b0;
        expect_out("rel", 1'b0, 32'h0, 32'h0);
        chk("rel.rom_a", rom_a, 32'h0);

        // streaming
        tick(); expect_out("s0", 1'b1, 32'h0, 32'h1000);
        chk("s0.rom_a", rom_a, 32'h4);
        tick(); expect_out("s1", 1'b1, 32'h4, 32'h1001);
        tick(); out_ready = 1'b0;
        expect_out("st0", 1'b1, 32'h8, 32'h1002);
        chk("st0.rom_a", rom_a, 32'hC);
        tick(); expect_out("st1", 1'b1, 32'h8, 32'h1002);
        chk("st1.rom_a", rom_a, 32'hC);
        tick(); expect_out("st2", 1'b1, 32'h8, 32'h1002);
        chk("st2.rom_a", rom_a, 32'hC);
        tick(); out_ready = 1'b1;
        expect_out("drain", 1'b1, 32'h8, 32'h1002);
        chk("drain.rom_a", rom_a, 32'hC);
        tick(); expect_out("after", 1'b1, 32'hC, 32'h1003);

        // redirect while streaming
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h40;
        expect_out("rd", 1'b0, 32'h0, 32'h0);
        chk("rd.rom_a", rom_a, 32'h40);
        tick(); redirect_valid = 1'b0;
        expect_out("rd0", 1'b1, 32'h40, 32'h1010);
        tick(); expect_out("rd1", 1'b1, 32'h44, 32'h1011);

        // fill skid, then redirect to an unaligned target with out_ready low
        tick(); out_ready = 1'b0;
        expect_out("fill", 1'b1, 32'h48, 32'h1012);
        tick(); expect_out("held", 1'b1, 32'h48, 32'h1012);
        chk("held.skid", {31'b0, dut.skid_v}, 32'h1);
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h83;
        expect_out("rdsk", 1'b0, 32'h0, 32'h0);
        chk("rdsk.rom_a", rom_a, 32'h80);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1;
        expect_out("rdsk0", 1'b1, 32'h80, 32'h1020);

        // redirect to the top of the address space, pc wraps to 0
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        expect_out("wrap", 1'b0, 32'h0, 32'h0);
        chk("wrap.rom_a", rom_a, 32'hFFFF_FFFC);
        tick(); redirect_valid = 1'b0;
        expect_out("wrap0", 1'b1, 32'hFFFF_FFFC, 32'h4000_0FFF);
        chk("wrap0.rom_a", rom_a, 32'h0);
        tick(); expect_out("wrap1", 1'b1, 32'h0, 32'h1000);

        // async reset pulse while the skid holds an entry
        tick(); out_ready = 1'b0;
        expect_out("pre", 1'b1, 32'h4, 32'h1001);
        tick(); expect_out("pre2", 1'b1, 32'h4, 32'h1001);
        RST = 1'b1;
        expect_out("arst", 1'b0, 32'h0, 32'h0);
        chk("arst.rom_a", rom_a, 32'h0);
        tick(); RST = 1'b0; out_ready = 1'b1;
        expect_out("rel2", 1'b0, 32'h0, 32'h0);
        chk("rel2.rom_a", rom_a, 32'h0);
        tick(); expect_out("rs0", 1'b1, 32'h0, 32'h1000);
        tick(); expect_out("rs1", 1'b1, 32'h4, 32'h1001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
